mem_access_stage: RTL

//  MEM stage: consumes EX/MEM register outputs, runs the data-memory req/gnt/rvalid handshake, stalls the pipe while access is outstanding.

---
 rtl/mem_access_stage_pkg.sv | 14 +
 rtl/mem_access_stage_mem_wb_reg.sv | 33 +++
 rtl/mem_access_stage.sv | 117 +++++++++++
 3 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared types and widths for the MEM pipeline stage.
// Imported by the MEM/WB register and the stage top.
package mem_access_stage_pkg;

    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_access_stage_mem_wb_reg.sv
// MEM/WB pipeline register.
// A bubble clears the destination and write enable.
module mem_wb_reg
    import mem_access_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  bubble,
    input  logic [XLEN-1:0]       data,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic                  reg_write_en,
    output logic [XLEN-1:0]       wb_data,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  wb_reg_write_en
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_data         <= '0;
            wb_rd           <= '0;
            wb_reg_write_en <= 1'b0;
        end else if (bubble) begin
            wb_data         <= '0;
            wb_rd           <= '0;
            wb_reg_write_en <= 1'b0;
        end else begin
            wb_data         <= data;
            wb_rd           <= rd;
            wb_reg_write_en <= reg_write_en;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: data-memory req/gnt/rvalid handshake, pipeline stall
// generation, access error detection and the MEM/WB register.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [XLEN-1:0]       alu_out,
    input  logic [XLEN-1:0]       data,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic                  mem_to_reg,
    input  logic                  reg_write_en,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_W-1:0]     dmem_addr,
    output logic [XLEN-1:0]       dmem_wdata,
    input  logic                  dmem_gnt,
    input  logic                  dmem_rvalid,
    input  logic [XLEN-1:0]       dmem_rdata,
    output logic                  stall,
    output logic                  mem_err,
    output logic [XLEN-1:0]       wb_data,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  wb_reg_write_en
);

    mem_state_e      state;
    mem_state_e      state_nxt;
    logic            op;
    logic            misalign;
    logic            err;
    logic            go;
    logic            done;
    logic            req_raw;
    logic            bubble;
    logic [XLEN-1:0] wb_mux;

    always_comb begin
        op       = mem_read | mem_write;
        misalign = CHECK_ALIGN && (alu_out[2:0] != 3'b000);
        err      = (state == IDLE) && op &&
                   ((mem_read && mem_write) || misalign);
        go        = op && !err;
        state_nxt = state;
        req_raw   = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (go) begin
                    req_raw = 1'b1;
                    if (!dmem_gnt)
                        state_nxt = REQ;
                    else if (mem_write)
                        done = 1'b1;
                    else
                        state_nxt = RESP;
                end
            end
            REQ: begin
                req_raw = 1'b1;
                if (dmem_gnt) begin
                    if (mem_write) begin
                        done      = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = RESP;
                    end
                end
            end
            RESP: begin
                if (dmem_rvalid) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request and stall drop the moment reset asserts, not at the next edge.
    assign dmem_req   = reset & req_raw;
    assign stall      = reset & go & ~done;
    assign dmem_we    = mem_write;
    assign dmem_addr  = alu_out[ADDR_W-1:0];
    assign dmem_wdata = data;

    assign bubble = stall | err;
    assign wb_mux = (state == RESP && mem_to_reg) ? dmem_rdata : alu_out;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            mem_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            mem_err <= err;
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .clk             (clk),
        .reset           (reset),
        .bubble          (bubble),
        .data            (wb_mux),
        .rd              (rd),
        .reg_write_en    (reg_write_en),
        .wb_data         (wb_data),
        .wb_rd           (wb_rd),
        .wb_reg_write_en (wb_reg_write_en)
    );

endmodule
